// File: rtl/elevator_pkg.sv
// elevator_pkg: shared car states, default timing constants and floor index type
package elevator_pkg;
   localparam int DEFAULT_NUM_FLOORS = 8;
   localparam int DEFAULT_TRAVEL_CYCLES = 16;
   localparam int DEFAULT_DOOR_CYCLES = 32;
   localparam int DEFAULT_FLOOR_W = $clog2(DEFAULT_NUM_FLOORS);
   typedef logic [DEFAULT_FLOOR_W-1:0] floor_t;
   typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERG} car_state_e;
endpackage

// File: rtl/car_request_reg.sv
// car_request_reg: latched floor requests (clk, reset, floor_req, clear, at_floor in; pending, req_above/below/here out relative to at_floor)
module car_request_reg import elevator_pkg::*; #(
   parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
   localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] floor_req,
   input  logic                  clear,
   input  logic [FLOOR_W-1:0]    at_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  req_above,
   output logic                  req_below,
   output logic                  req_here
);
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   assign pending_d = (pending_q | floor_req) & ~({{(NUM_FLOORS-1){1'b0}}, clear} << at_floor);
   always_comb begin
      req_above = 1'b0;
      req_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         req_above = req_above | (pending_q[i] && i > int'(at_floor));
         req_below = req_below | (pending_q[i] && i < int'(at_floor));
      end
   end
   always_ff @(posedge clk) pending_q <= reset ? '0 : pending_d;
   assign pending = pending_q;
   assign req_here = pending_q[at_floor];
endmodule

// File: rtl/car_motion_controller.sv
// car_motion_controller: SCAN car FSM with travel/door timers and emergency freeze (clk, reset, floor_req, emergency_stopped in; current_floor, moving_up/down, door_open, pending, in_emergency out)
module car_motion_controller import elevator_pkg::*; #(
   parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
   parameter int TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES,
   parameter int DOOR_CYCLES = DEFAULT_DOOR_CYCLES,
   localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] floor_req,
   input  logic                  emergency_stopped,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  in_emergency
);
   localparam int TW = $clog2(TRAVEL_CYCLES);
   localparam int DW = $clog2(DOOR_CYCLES);
   car_state_e state_q, state_d, resume_q, resume_d;
   logic [TW-1:0] travel_q, travel_d;
   logic [DW-1:0] door_q, door_d;
   logic [FLOOR_W-1:0] floor_q, floor_d;
   logic dir_up_q, dir_up_d;
   logic moving, arrive, door_done, door_hit, clear, req_above, req_below, req_here;
   assign moving = state_q == MOVE_UP || state_q == MOVE_DOWN;
   assign arrive = moving && !emergency_stopped && travel_q == TW'(TRAVEL_CYCLES - 1);
   assign floor_d = !arrive ? floor_q : state_q == MOVE_UP ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
   assign door_done = door_q == DW'(DOOR_CYCLES - 1);
   assign door_hit = floor_req[floor_q];
   assign clear = state_q == DOOR_OPEN || state_d == DOOR_OPEN;
   assign dir_up_d = state_d == MOVE_UP ? 1'b1 : state_d == MOVE_DOWN ? 1'b0 : dir_up_q;
   car_request_reg #(.NUM_FLOORS(NUM_FLOORS)) u_req (
      .clk      (clk),
      .reset    (reset),
      .floor_req(floor_req),
      .clear    (clear),
      .at_floor (floor_d),
      .pending  (pending),
      .req_above(req_above),
      .req_below(req_below),
      .req_here (req_here)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         resume_q <= IDLE;
         floor_q <= '0;
         travel_q <= '0;
         door_q <= '0;
         dir_up_q <= 1'b1;
      end else begin
         state_q <= state_d;
         resume_q <= resume_d;
         floor_q <= floor_d;
         travel_q <= travel_d;
         door_q <= door_d;
         dir_up_q <= dir_up_d;
      end
   end
   always_comb begin
      state_d = state_q;
      resume_d = resume_q;
      travel_d = travel_q;
      door_d = door_q;
      if (emergency_stopped && state_q != EMERG) begin
         state_d = EMERG;
         resume_d = state_q;
      end else begin
         case (state_q)
            IDLE: state_d = req_here ? DOOR_OPEN : (req_above && (dir_up_q || !req_below)) ? MOVE_UP : req_below ? MOVE_DOWN : IDLE;
            MOVE_UP, MOVE_DOWN: begin
               travel_d = arrive ? '0 : travel_q + TW'(1);
               state_d = !arrive ? state_q : req_here ? DOOR_OPEN : (state_q == MOVE_UP ? req_above : req_below) ? state_q : IDLE;
            end
            DOOR_OPEN: begin
               door_d = (door_hit || door_done) ? '0 : door_q + DW'(1);
               state_d = (door_done && !door_hit) ? IDLE : DOOR_OPEN;
            end
            EMERG: begin
               state_d = emergency_stopped ? EMERG : resume_q;
               door_d = (!emergency_stopped && resume_q == DOOR_OPEN) ? '0 : door_q;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_comb begin
      moving_up = state_q == MOVE_UP;
      moving_down = state_q == MOVE_DOWN;
      door_open = state_q == DOOR_OPEN;
      in_emergency = state_q == EMERG;
   end
   assign current_floor = floor_q;
endmodule

// File: tb/tb_car_motion_controller.sv
// tb_car_motion_controller: directed and randomized checking of car_motion_controller against a behavioural car model
module tb_car_motion_controller;
   localparam int N = 8;
   localparam int T = 4;
   localparam int D = 6;
   localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_DOOR = 3, M_EMG = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic emergency_stopped = 1'b0;
   logic [N-1:0] floor_req = '0;
   logic [2:0] current_floor;
   logic moving_up, moving_down, door_open, in_emergency;
   logic [N-1:0] pending;
   int checks = 0;
   int errors = 0;
   int emg_left = 0;
   bit run_cmp = 1'b0;
   int m_mode, m_saved, m_left, m_dwell, m_floor;
   bit m_up, was_door;
   bit [N-1:0] m_pend, old;
   always #5 clk = ~clk;
   car_motion_controller #(.NUM_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
      .clk              (clk),
      .reset            (reset),
      .floor_req        (floor_req),
      .emergency_stopped(emergency_stopped),
      .current_floor    (current_floor),
      .moving_up        (moving_up),
      .moving_down      (moving_down),
      .door_open        (door_open),
      .pending          (pending),
      .in_emergency     (in_emergency)
   );
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   function automatic bit beyond(input bit [N-1:0] p, input int f, input bit up);
      for (int i = 0; i < N; i++) if (p[i] && (up ? i > f : i < f)) return 1'b1;
      return 1'b0;
   endfunction
   // Car model: countdowns of remaining travel/dwell cycles, frozen while stopped.
   always @(posedge clk) begin
      if (reset) begin
         m_mode = M_IDLE;
         m_saved = M_IDLE;
         m_floor = 0;
         m_pend = '0;
         m_up = 1'b1;
         m_left = 0;
         m_dwell = 0;
      end else begin
         old = m_pend;
         was_door = m_mode == M_DOOR;
         if (emergency_stopped && m_mode != M_EMG) begin
            m_saved = m_mode;
            m_mode = M_EMG;
         end else if (m_mode == M_EMG) begin
            if (!emergency_stopped) begin
               m_mode = m_saved;
               if (m_mode == M_DOOR) m_dwell = D;
            end
         end else if (m_mode == M_IDLE) begin
            if (old[m_floor]) begin
               m_mode = M_DOOR;
               m_dwell = D;
            end else if (beyond(old, m_floor, 1'b1) && (m_up || !beyond(old, m_floor, 1'b0))) begin
               m_mode = M_UP;
               m_up = 1'b1;
               m_left = T;
            end else if (beyond(old, m_floor, 1'b0)) begin
               m_mode = M_DN;
               m_up = 1'b0;
               m_left = T;
            end
         end else if (m_mode != M_DOOR) begin
            m_left--;
            if (m_left == 0) begin
               m_floor += m_up ? 1 : -1;
               if (old[m_floor]) begin
                  m_mode = M_DOOR;
                  m_dwell = D;
               end else if (beyond(old, m_floor, m_up)) m_left = T;
               else m_mode = M_IDLE;
            end
         end else if (floor_req[m_floor]) m_dwell = D;
         else begin
            m_dwell--;
            if (m_dwell == 0) m_mode = M_IDLE;
         end
         m_pend = old | floor_req;
         if (was_door || m_mode == M_DOOR) m_pend[m_floor] = 1'b0;
      end
   end
   always @(negedge clk) begin
      if (run_cmp) begin
         check("current_floor", current_floor, m_floor);
         check("moving_up", moving_up, m_mode == M_UP);
         check("moving_down", moving_down, m_mode == M_DN);
         check("door_open", door_open, m_mode == M_DOOR);
         check("in_emergency", in_emergency, m_mode == M_EMG);
         check("pending", pending, m_pend);
      end
   end
   initial begin
      step(2);
      reset = 1'b0;
      run_cmp = 1'b1;
      check("rst_floor", current_floor, 0);
      check("rst_outs", {moving_up, moving_down, door_open, in_emergency}, 0);
      check("rst_pending", pending, 0);
      floor_req = 8'h08;
      step(1);
      floor_req = '0;
      check("t1_latched", pending, 8'h08);
      check("t1_still_idle", moving_up, 0);
      step(1);
      check("t1_move_up", moving_up, 1);
      step(4);
      check("t1_floor1", current_floor, 1);
      step(8);
      check("t1_floor3", current_floor, 3);
      check("t1_door", door_open, 1);
      check("t1_cleared", pending, 0);
      step(5);
      check("t1_door_last", door_open, 1);
      step(1);
      check("t1_door_closed", door_open, 0);
      floor_req = 8'h20;
      step(1);
      floor_req = '0;
      step(1);
      check("t3_move_up", moving_up, 1);
      step(2);
      emergency_stopped = 1'b1;
      step(1);
      check("t3_emerg", in_emergency, 1);
      check("t3_motor_off", moving_up, 0);
      step(9);
      emergency_stopped = 1'b0;
      step(1);
      check("t3_resume", moving_up, 1);
      step(1);
      check("t3_not_yet", current_floor, 3);
      step(1);
      check("t3_arrive", current_floor, 4);
      step(40);
      check("t3_at5", current_floor, 5);
      floor_req = 8'h82;
      step(1);
      floor_req = '0;
      step(9);
      check("t2_top_first", current_floor, 7);
      check("t2_door7", door_open, 1);
      step(31);
      check("t2_floor1", current_floor, 1);
      check("t2_door1", door_open, 1);
      step(10);
      floor_req = 8'h02;
      step(1);
      floor_req = '0;
      step(1);
      check("t4_door", door_open, 1);
      step(3);
      emergency_stopped = 1'b1;
      step(1);
      check("t4_door_off", door_open, 0);
      step(4);
      emergency_stopped = 1'b0;
      step(1);
      check("t4_door_back", door_open, 1);
      step(5);
      check("t4_full_dwell", door_open, 1);
      step(1);
      check("t4_closed", door_open, 0);
      floor_req = 8'h02;
      step(1);
      floor_req = '0;
      step(4);
      floor_req = 8'h02;
      step(1);
      floor_req = '0;
      check("t5_absorbed", pending, 0);
      step(5);
      check("t5_extended", door_open, 1);
      step(1);
      check("t5_closed", door_open, 0);
      for (int c = 0; c < 4000; c++) begin
         floor_req = '0;
         if ($urandom_range(0, 7) == 0) floor_req[$urandom_range(0, N - 1)] = 1'b1;
         if ($urandom_range(0, 63) == 0) floor_req = N'($urandom);
         if (emg_left > 0) emg_left--;
         else if ($urandom_range(0, 149) == 0) emg_left = $urandom_range(1, 15);
         emergency_stopped = emg_left > 0;
         reset = $urandom_range(0, 1499) == 0;
         step(1);
      end
      floor_req = '0;
      emergency_stopped = 1'b0;
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("t6_rst_floor", current_floor, 0);
      check("t6_rst_outs", {moving_up, moving_down, door_open, in_emergency}, 0);
      floor_req = 8'h01;
      step(1);
      floor_req = '0;
      step(1);
      check("t6_door0", door_open, 1);
      check("t6_no_motion", {moving_up, moving_down}, 0);
      check("t6_cleared", pending, 0);
      step(6);
      floor_req = 8'h80;
      step(1);
      floor_req = '0;
      step(9);
      check("t6_moving", moving_up, 1);
      check("t6_floor2", current_floor, 2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("t6_mid_rst_floor", current_floor, 0);
      check("t6_mid_rst_motor", moving_up, 0);
      check("t6_mid_rst_pending", pending, 0);
      step(2);
      run_cmp = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
